// File: rtl/cell_writer.sv
// cell_writer: stores a sudoku cell and draws its 8x8 digit glyph into the framebuffer,
// keeping a live count of filled cells.
module cell_writer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_write,
    input  logic [3:0] cell_row,
    input  logic [3:0] cell_col,
    input  logic [3:0] cell_data,
    output logic       working,
    output logic       fb_we,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_data,
    input  logic [3:0] rd_row,
    input  logic [3:0] rd_col,
    output logic [3:0] rd_data,
    output logic [6:0] cells_filled,
    output logic       board_full,
    output logic       coord_err
);
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [63:0] GLYPH [10] = '{
        64'h0000000000000000, 64'h1838181818187E00, 64'h3C66060C30607E00,
        64'h3C66061C06663C00, 64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00,
        64'h3C607C6666663C00, 64'h7E060C1830303000, 64'h3C66663C66663C00,
        64'h3C66663E060C3800
    };

    function automatic logic [7:0] glyph(input logic [3:0] d, input logic [2:0] l);
        return (d > 4'd9) ? 8'h00 : GLYPH[d][{3'd7 - l, 3'b000} +: 8];
    endfunction

    state_t     state;
    logic [3:0] board [81];
    logic       sw_q;
    logic       primed;
    logic       err_pend;
    logic [2:0] line;
    logic [3:0] dat;
    logic       rise;
    logic       valid;
    logic [3:0] wr_d;
    logic [3:0] old_d;
    logic [6:0] wr_idx;
    logic [6:0] rd_idx;

    // primed suppresses a false edge when start_write is already high as reset releases
    assign rise       = start_write & ~sw_q & primed;
    assign valid      = (cell_row <= 4'd8) && (cell_col <= 4'd8);
    assign wr_d       = (cell_data > 4'd9) ? 4'd0 : cell_data;
    assign wr_idx     = {3'b000, cell_row} * 7'd9 + {3'b000, cell_col};
    assign rd_idx     = {3'b000, rd_row} * 7'd9 + {3'b000, rd_col};
    assign old_d      = board[wr_idx];
    assign rd_data    = (rd_row <= 4'd8 && rd_col <= 4'd8) ? board[rd_idx] : 4'd0;
    assign board_full = cells_filled == 7'd81;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sw_q         <= 1'b0;
            primed       <= 1'b0;
            err_pend     <= 1'b0;
            coord_err    <= 1'b0;
            working      <= 1'b0;
            fb_we        <= 1'b0;
            fb_addr      <= '0;
            fb_data      <= '0;
            line         <= '0;
            dat          <= '0;
            cells_filled <= '0;
            for (int i = 0; i < 81; i++) board[i] <= '0;
        end else begin
            sw_q      <= start_write;
            primed    <= 1'b1;
            err_pend  <= 1'b0;
            coord_err <= err_pend;
            case (state)
                IDLE: begin
                    if (rise && valid) begin
                        state         <= DRAW;
                        line          <= '0;
                        dat           <= wr_d;
                        working       <= 1'b1;
                        fb_we         <= 1'b1;
                        fb_addr       <= {wr_idx, 3'b000};
                        fb_data       <= glyph(wr_d, 3'd0);
                        board[wr_idx] <= wr_d;
                        cells_filled  <= cells_filled + {6'b0, wr_d != 4'd0 && old_d == 4'd0}
                                                      - {6'b0, wr_d == 4'd0 && old_d != 4'd0};
                    end else if (rise) begin
                        err_pend <= 1'b1;
                    end
                end
                DRAW: begin
                    if (line == 3'd7) begin
                        state <= DONE;
                        fb_we <= 1'b0;
                    end else begin
                        line    <= line + 3'd1;
                        fb_addr <= fb_addr + 10'd1;
                        fb_data <= glyph(dat, line + 3'd1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    working <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cell_writer.sv
// tb_cell_writer: randomized scoreboard bench for cell_writer against a board/glyph reference model.
module tb_cell_writer;
    logic       clk, rst_n, start_write;
    logic [3:0] cell_row, cell_col, cell_data, rd_row, rd_col, rd_data;
    logic       working, fb_we, board_full, coord_err;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic [6:0] cells_filled;

    cell_writer dut (
        .clk(clk), .rst_n(rst_n), .start_write(start_write),
        .cell_row(cell_row), .cell_col(cell_col), .cell_data(cell_data),
        .working(working), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .cells_filled(cells_filled), .board_full(board_full), .coord_err(coord_err)
    );

    localparam logic [7:0] GL [10][8] = '{
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00}
    };

    typedef struct {int addr; int data;} exp_t;
    exp_t fbq[$];
    int   mb [81];
    int   errp = 0;
    int   n_pass = 0, n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < 81; i++) n += (mb[i] != 0) ? 1 : 0;
        return n;
    endfunction

    // live=0 marks a request the DUT must ignore because it is busy
    task automatic do_write(input int r, input int c, input int d, input bit live);
        int dd = (d > 9) ? 0 : d;
        int idx = r * 9 + c;
        bit ok = (r <= 8) && (c <= 8);
        @(negedge clk);
        cell_row = 4'(r); cell_col = 4'(c); cell_data = 4'(d); start_write = 1'b1;
        if (live && ok) begin
            for (int l = 0; l < 8; l++) fbq.push_back('{addr: idx * 8 + l, data: int'(GL[dd][l])});
            mb[idx] = dd;
        end
        if (live && !ok) errp++;
        @(negedge clk);
        start_write = 1'b0;
        cell_row = 4'($urandom); cell_col = 4'($urandom); cell_data = 4'($urandom);
        if (live && ok) begin
            rd_row = 4'(r); rd_col = 4'(c);
            #1 chk("rd_new", rd_data, mb[idx]);
        end
        if (live && !ok) begin
            chk("err_working", working, 0);
            chk("err_early", coord_err, 0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (working && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", (n < 30) ? 1 : 0, 1);
        chk("cells_filled", cells_filled, model_cnt());
        chk("board_full", board_full, (model_cnt() == 81) ? 1 : 0);
    endtask

    task automatic chk_cell(input string nm, input int r, input int c, input int exp);
        rd_row = 4'(r); rd_col = 4'(c);
        #1 chk(nm, rd_data, exp);
    endtask

    initial begin : monitor
        int wl = 0, fl = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fbq.delete();
                wl = 0; fl = 0;
            end else begin
                if (working) wl++;
                else if (wl != 0) begin chk("working_len", wl, 9); wl = 0; end
                if (fb_we) begin
                    fl++;
                    if (fbq.size() == 0) chk("fb_spurious", fb_we, 0);
                    else begin
                        e = fbq.pop_front();
                        chk("fb_addr", fb_addr, e.addr);
                        chk("fb_data", fb_data, e.data);
                    end
                end else if (fl != 0) begin chk("fb_len", fl, 8); fl = 0; end
                if (coord_err) begin
                    if (errp > 0) begin chk("coord_err", coord_err, 1); errp--; end
                    else chk("coord_err_spurious", coord_err, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        int nz;
        for (int i = 0; i < 81; i++) mb[i] = 0;
        rst_n = 1'b0; start_write = 1'b0;
        cell_row = '0; cell_col = '0; cell_data = '0; rd_row = 4'd2; rd_col = 4'd3;
        repeat (3) @(negedge clk);
        chk("rst_working", working, 0);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_coord_err", coord_err, 0);
        chk("rst_cells", cells_filled, 0);
        chk("rst_full", board_full, 0);
        chk("rst_rd", rd_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_write(2, 3, 5, 1); wait_idle();
        chk_cell("rd_23_5", 2, 3, 5);
        do_write(2, 3, 0, 1); wait_idle();
        chk_cell("rd_23_0", 2, 3, 0);
        do_write(0, 0, 12, 1); wait_idle();
        chk_cell("rd_data12", 0, 0, 0);

        do_write(9, 0, 3, 1); wait_idle();
        do_write(0, 9, 3, 1); wait_idle();
        do_write(15, 15, 1, 1); wait_idle();
        chk_cell("rd_oob", 9, 0, 0);

        do_write(1, 1, 4, 1);
        repeat (2) @(negedge clk);
        do_write(4, 4, 7, 0); wait_idle();
        do_write(5, 5, 8, 1); wait_idle();
        chk_cell("ignored_cell", 4, 4, mb[40]);

        for (int k = 0; k < 40; k++) begin
            int r = ($urandom % 8 == 0) ? 9 + int'($urandom % 7) : int'($urandom % 9);
            do_write(r, int'($urandom % 9), int'($urandom % 16), 1);
            wait_idle();
        end

        for (int i = 0; i < 81; i++) begin
            do_write(i / 9, i % 9, 1 + int'($urandom % 9), 1);
            wait_idle();
        end
        chk("full_cells", cells_filled, 81);
        chk("full_flag", board_full, 1);
        do_write(0, 0, 0, 1); wait_idle();
        do_write(0, 0, 3, 1); wait_idle();

        do_write(3, 4, 6, 1);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0; start_write = 1'b1;
        #1 chk("abort_working", working, 0);
        chk("abort_fb_we", fb_we, 0);
        for (int i = 0; i < 81; i++) mb[i] = 0;
        nz = 0;
        for (int i = 0; i < 81; i++) begin
            rd_row = 4'(i / 9); rd_col = 4'(i % 9);
            #1 nz += (rd_data != 4'd0) ? 1 : 0;
        end
        chk("rst_board_clear", nz, 0);
        chk("rst_cells_clear", cells_filled, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_retrigger", working, 0);
        end
        start_write = 1'b0;
        @(negedge clk);
        do_write(3, 4, 6, 1); wait_idle();
        chk_cell("after_rst_write", 3, 4, 6);

        repeat (3) @(negedge clk);
        chk("fb_queue_empty", fbq.size(), 0);
        chk("err_pending", errp, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cell_writer.md
CELL_WRITER -- requirements
Module: cell_writer

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset; all state resets immediately on rst_n low.
REQ-002 SHALL have ports: clk  in  1  system clock (rising edge).
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start_write  in  1  cell-ready strobe from board_sync; rising edge requests one cell write.
REQ-005 cell_row  in  4  board row 0..8, valid when the start_write edge is sampled.
REQ-006 cell_col  in  4  board column 0..8, valid with cell_row.
REQ-007 cell_data  in  4  digit 1..9, or 0 for blank.
REQ-008 working  out  1  busy indication back to board_sync; high while the cell is processed.
REQ-009 fb_we  out  1  framebuffer write enable.
REQ-010 fb_addr  out  10  framebuffer address = (row*9+col)*8 + line; maximum 647.
REQ-011 fb_data  out  8  glyph pixel row; bit 7 is the leftmost pixel.
REQ-012 rd_row/rd_col  in  4 each  board readback address.
REQ-013 rd_data  out  4  combinational readback of stored cell; 0 when the address is out of range.
REQ-014 cells_filled  out  7  count of non-zero cells, 0..81.
REQ-015 board_full  out  1  high when cells_filled==81.
REQ-016 coord_err  out  1  one-cycle pulse when a request is rejected.

Function
REQ-017 SHALL register start_write and detect a rising edge as start_write=1 with the previous sample 0.
- A level held high SHALL NOT retrigger.
REQ-018 SHALL implement the FSM states IDLE, DRAW, DONE; edge N is the first edge at which the rising edge is seen in IDLE.
REQ-019 At edge N with row<=8 and col<=8, the block SHALL:
- enter DRAW with line=0;
- set working=1 and fb_we=1;
- set fb_addr=base, fb_data=glyph(data, 0);
- write board[row][col]<=data.
REQ-020 Edges N+1..N+7 SHALL increment line 1..7, updating fb_addr=base+line and fb_data=glyph(data, line), with fb_we held 1.
REQ-021 At edge N+8 the block SHALL go DRAW->DONE with fb_we=0 and working still 1.
REQ-022 At edge N+9 the block SHALL go DONE->IDLE with working=0; working is high for exactly 9 cycles and fb_we for exactly 8.
REQ-023 cell_row, cell_col and cell_data SHALL be latched at edge N; input changes after edge N SHALL NOT affect the write in progress.
REQ-024 Glyph lookup SHALL use an internal 10x8x8 table.
- Data 0 SHALL produce 8'h00 on every line.
- Data 10..15 SHALL be treated as 0, both in the glyph and in the stored value.
REQ-025 Any start_write edge outside IDLE SHALL be ignored (not queued); board_sync waits for working low.
REQ-026 A request with row>8 or col>8 SHALL:
- pulse coord_err for 1 cycle at edge N+1;
- keep the board, the FSM in IDLE, fb_we=0 and working=0.
REQ-027 cells_filled SHALL update at edge N:
- +1 when writing non-zero over 0;
- -1 when writing 0 over non-zero;
- unchanged otherwise;
- never outside 0..81.
REQ-028 A readback of the cell being written SHALL return the new value from the cycle after edge N.

Reset
REQ-029 Reset SHALL set: FSM=IDLE, working=0, fb_we=0, fb_addr=0, fb_data=0, coord_err=0, all 81 cells=0, cells_filled=0, board_full=0, edge-detect register=0.
REQ-030 Reset asserted mid-DRAW SHALL abort the write immediately, with fb_we and working low asynchronously.
- Board contents SHALL be cleared.
- After release, the block SHALL wait for a fresh start_write rising edge.
REQ-031 If start_write is already high when reset releases, it SHALL NOT be treated as an edge.

Verification
REQ-032 Write row=2, col=3, data=5 -> working high 9 cycles; fb_we high 8 cycles; fb_addr 168..175; fb_data equals glyph(5); rd_data at (2,3)=5; cells_filled=1.
REQ-033 Write (2,3)=0 after REQ-032 -> fb_data=8'h00 for 8 lines at addr 168..175; cells_filled=0.
REQ-034 Two back-to-back requests with the second edge arriving while working=1, then a third after working low -> only the first and third are drawn; second ignored.
REQ-035 Request with row=9, col=0 -> coord_err 1-cycle pulse; working stays 0; fb_we stays 0; cells_filled unchanged.
REQ-036 Fill all 81 cells with 1..9 -> cells_filled=81 and board_full=1; last cell (8,8) uses fb_addr 640..647.
REQ-037 Assert rst_n low at line 4 of a draw -> working=0 and fb_we=0 immediately; all rd_data=0; start_write held high across release does not trigger.
